// File: rtl/rat_ckpt.sv
// Register alias table: maps architectural registers to ROB tags, with a ring of
// branch checkpoints that restore the map on mispredict and clear on full flush.
module rat_ckpt #(
   parameter  int ARCH_REGS = 32,
   parameter  int ROB_DEPTH = 16,
   parameter  int RD_PORTS  = 3,
   parameter  int CKPT_NUM  = 4,
   localparam int AW        = $clog2(ARCH_REGS),
   localparam int TW        = $clog2(ROB_DEPTH),
   localparam int CW        = $clog2(CKPT_NUM)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [RD_PORTS*AW-1:0] rd_addr,
   output logic [RD_PORTS-1:0]    rd_valid,
   output logic [RD_PORTS*TW-1:0] rd_tag,
   input  logic                   alloc_en,
   input  logic [TW-1:0]          alloc_tag,
   input  logic [AW-1:0]          alloc_dst,
   input  logic                   alloc_wen,
   input  logic                   alloc_ckpt,
   output logic [CW-1:0]          ckpt_alloc_id,
   output logic                   ckpt_full,
   output logic [CW:0]            ckpt_cnt,
   input  logic                   commit_en,
   input  logic [AW-1:0]          commit_dst,
   input  logic [TW-1:0]          commit_tag,
   input  logic                   commit_ckpt_free,
   input  logic                   recover_en,
   input  logic [CW-1:0]          recover_id,
   input  logic                   flush_en
);

   logic [ARCH_REGS-1:0] map_v_q, map_v_d;
   logic [TW-1:0]        map_tag_q [ARCH_REGS];
   logic [TW-1:0]        map_tag_d [ARCH_REGS];
   logic [ARCH_REGS-1:0] ck_v_q    [CKPT_NUM];
   logic [ARCH_REGS-1:0] ck_v_d    [CKPT_NUM];
   logic [TW-1:0]        ck_tag_q  [CKPT_NUM][ARCH_REGS];
   logic [TW-1:0]        ck_tag_d  [CKPT_NUM][ARCH_REGS];
   logic [CW-1:0]        ck_head_q, ck_head_d;
   logic [CW-1:0]        ck_tail_q, ck_tail_d;
   logic [CW:0]          ck_cnt_q,  ck_cnt_d;

   logic          commit_clr;
   logic          free_req;
   logic          free_ok;
   logic          alloc_ok;
   logic          ckpt_take;
   logic [CW-1:0] rec_dist;

   assign ckpt_full  = (ck_cnt_q == (CW+1)'(CKPT_NUM));
   assign commit_clr = commit_en && (commit_dst != '0);
   assign free_req   = commit_en && commit_ckpt_free;
   assign free_ok    = free_req && (ck_cnt_q != '0);
   // A checkpoint request while full is a protocol error; the whole slot is dropped.
   assign alloc_ok   = alloc_en && !recover_en && !(alloc_ckpt && ckpt_full);
   assign ckpt_take  = alloc_ok && alloc_ckpt;
   assign rec_dist   = recover_id - ck_head_q;

   always_comb begin
      // NOTE: every next-state variable is given a default before any condition so no latch is inferred.
      map_v_d   = map_v_q;
      map_tag_d = map_tag_q;
      ck_v_d    = ck_v_q;
      ck_tag_d  = ck_tag_q;
      ck_head_d = ck_head_q;
      ck_tail_d = ck_tail_q;
      ck_cnt_d  = ck_cnt_q;

      if (recover_en) begin
         map_v_d   = ck_v_q[recover_id];
         map_tag_d = ck_tag_q[recover_id];
      end

      // Retirement clears live and snapshot copies alike, so no restore revives it.
      if (commit_clr) begin
         if (map_v_d[commit_dst] && (map_tag_d[commit_dst] == commit_tag))
            map_v_d[commit_dst] = 1'b0;
         for (int c = 0; c < CKPT_NUM; c++) begin
            if (ck_v_q[c][commit_dst] && (ck_tag_q[c][commit_dst] == commit_tag))
               ck_v_d[c][commit_dst] = 1'b0;
         end
      end

      if (recover_en) begin
         ck_tail_d = recover_id + 1'b1;
         ck_cnt_d  = {1'b0, rec_dist} + (CW+1)'(1) - (CW+1)'(free_req);
         ck_head_d = ck_head_q + CW'(free_req);
      end else begin
         if (alloc_ok && alloc_wen && (alloc_dst != '0)) begin
            map_v_d[alloc_dst]   = 1'b1;
            map_tag_d[alloc_dst] = alloc_tag;
         end
         if (ckpt_take) begin
            ck_v_d[ck_tail_q]   = map_v_d;
            ck_tag_d[ck_tail_q] = map_tag_d;
            ck_tail_d           = ck_tail_q + 1'b1;
         end
         ck_cnt_d  = ck_cnt_q + (CW+1)'(ckpt_take) - (CW+1)'(free_ok);
         ck_head_d = ck_head_q + CW'(free_ok);
      end

      if (flush_en) begin
         map_v_d = '0;
         for (int c = 0; c < CKPT_NUM; c++) ck_v_d[c] = '0;
         ck_head_d = '0;
         ck_tail_d = '0;
         ck_cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         map_v_q <= '0;
         for (int c = 0; c < CKPT_NUM; c++) ck_v_q[c] <= '0;
         ck_head_q <= '0;
         ck_tail_q <= '0;
         ck_cnt_q  <= '0;
      end else begin
         map_v_q   <= map_v_d;
         ck_v_q    <= ck_v_d;
         ck_head_q <= ck_head_d;
         ck_tail_q <= ck_tail_d;
         ck_cnt_q  <= ck_cnt_d;
      end
   end

   // NOTE: tag storage is deliberately left out of reset; valid bits gate every use of it.
   always_ff @(posedge clk) begin
      map_tag_q <= map_tag_d;
      ck_tag_q  <= ck_tag_d;
   end

   always_comb begin
      rd_valid = '0;
      rd_tag   = '0;
      for (int k = 0; k < RD_PORTS; k++) begin
         if ((rd_addr[k*AW +: AW] != '0) && map_v_q[rd_addr[k*AW +: AW]]) begin
            rd_valid[k]        = 1'b1;
            rd_tag[k*TW +: TW] = map_tag_q[rd_addr[k*AW +: AW]];
         end
      end
   end

   assign ckpt_alloc_id = ck_tail_q;
   assign ckpt_cnt      = ck_cnt_q;

endmodule

// File: tb/tb_rat_ckpt.sv
// Scoreboard bench for rat_ckpt: directed scenarios with hand-derived values plus a
// constrained random phase checked against an independent behavioural model.
module tb_rat_ckpt;

   localparam int AW = 5;
   localparam int TW = 4;
   localparam int CW = 2;
   localparam int NP = 3;
   localparam int NC = 4;
   localparam int NR = 32;

   localparam int K_CNT  = 0;
   localparam int K_FULL = 1;
   localparam int K_ID   = 2;
   localparam int K_RV   = 3;
   localparam int K_RT   = 4;

   typedef struct {
      string tag;
      int    kind;
      int    arg;
      int    port;
      int    exp;
   } sb_item_t;

   logic             clk;
   logic             rst_n;
   logic [NP*AW-1:0] rd_addr;
   logic [NP-1:0]    rd_valid;
   logic [NP*TW-1:0] rd_tag;
   logic             alloc_en;
   logic [TW-1:0]    alloc_tag;
   logic [AW-1:0]    alloc_dst;
   logic             alloc_wen;
   logic             alloc_ckpt;
   logic [CW-1:0]    ckpt_alloc_id;
   logic             ckpt_full;
   logic [CW:0]      ckpt_cnt;
   logic             commit_en;
   logic [AW-1:0]    commit_dst;
   logic [TW-1:0]    commit_tag;
   logic             commit_ckpt_free;
   logic             recover_en;
   logic [CW-1:0]    recover_id;
   logic             flush_en;

   rat_ckpt dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rd_addr          (rd_addr),
      .rd_valid         (rd_valid),
      .rd_tag           (rd_tag),
      .alloc_en         (alloc_en),
      .alloc_tag        (alloc_tag),
      .alloc_dst        (alloc_dst),
      .alloc_wen        (alloc_wen),
      .alloc_ckpt       (alloc_ckpt),
      .ckpt_alloc_id    (ckpt_alloc_id),
      .ckpt_full        (ckpt_full),
      .ckpt_cnt         (ckpt_cnt),
      .commit_en        (commit_en),
      .commit_dst       (commit_dst),
      .commit_tag       (commit_tag),
      .commit_ckpt_free (commit_ckpt_free),
      .recover_en       (recover_en),
      .recover_id       (recover_id),
      .flush_en         (flush_en)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_n    = 0;
   sb_item_t sbq[$];

   // Behavioural model of the table
   int m_v  [NR];
   int m_tag[NR];
   int m_cv [NC][NR];
   int m_ct [NC][NR];
   int m_head, m_tail, m_cnt;
   int probe[6];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc_n, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int kind, input int arg, input int exp);
      sb_item_t e;
      e.tag = tag; e.kind = kind; e.arg = arg; e.port = arg % NP; e.exp = exp;
      sbq.push_back(e);
   endtask

   task automatic idle();
      rst_n = 1'b1;
      alloc_en = 1'b0; alloc_tag = '0; alloc_dst = '0; alloc_wen = 1'b0; alloc_ckpt = 1'b0;
      commit_en = 1'b0; commit_dst = '0; commit_tag = '0; commit_ckpt_free = 1'b0;
      recover_en = 1'b0; recover_id = '0; flush_en = 1'b0;
   endtask

   task automatic model_apply();
      int cnt0, fr, rid, cd, ct, ad;
      if (!rst_n || flush_en) begin
         for (int r = 0; r < NR; r++) begin
            m_v[r] = 0;
            for (int c = 0; c < NC; c++) m_cv[c][r] = 0;
         end
         m_head = 0; m_tail = 0; m_cnt = 0;
         return;
      end
      cnt0 = m_cnt;
      fr   = (commit_en && commit_ckpt_free) ? 1 : 0;
      rid  = int'(recover_id);
      cd   = int'(commit_dst);
      ct   = int'(commit_tag);
      ad   = int'(alloc_dst);
      if (commit_en && cd != 0)
         for (int c = 0; c < NC; c++)
            if (m_cv[c][cd] != 0 && m_ct[c][cd] == ct) m_cv[c][cd] = 0;
      if (recover_en) begin
         for (int r = 0; r < NR; r++) begin
            m_v[r]   = m_cv[rid][r];
            m_tag[r] = m_ct[rid][r];
         end
         m_cnt  = ((rid - m_head + NC) % NC) + 1 - fr;
         m_head = (m_head + fr) % NC;
         m_tail = (rid + 1) % NC;
      end else begin
         if (commit_en && cd != 0 && m_v[cd] != 0 && m_tag[cd] == ct) m_v[cd] = 0;
         if (alloc_en && !(alloc_ckpt && cnt0 == NC)) begin
            if (alloc_wen && ad != 0) begin
               m_v[ad]   = 1;
               m_tag[ad] = int'(alloc_tag);
            end
            if (alloc_ckpt) begin
               for (int r = 0; r < NR; r++) begin
                  m_cv[m_tail][r] = m_v[r];
                  m_ct[m_tail][r] = m_tag[r];
               end
               m_tail = (m_tail + 1) % NC;
               m_cnt++;
            end
         end
         if (fr != 0 && cnt0 != 0) begin
            m_head = (m_head + 1) % NC;
            m_cnt--;
         end
      end
   endtask

   task automatic drain();
      sb_item_t e;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         case (e.kind)
            K_CNT:  check(e.tag, int'(ckpt_cnt), e.exp);
            K_FULL: check(e.tag, int'(ckpt_full), e.exp);
            K_ID:   check(e.tag, int'(ckpt_alloc_id), e.exp);
            K_RV: begin
               rd_addr[e.port*AW +: AW] = AW'(e.arg);
               #1;
               check(e.tag, int'(rd_valid[e.port]), e.exp);
            end
            default: begin
               rd_addr[e.port*AW +: AW] = AW'(e.arg);
               #1;
               check(e.tag, int'(rd_tag[e.port*TW +: TW]), e.exp);
            end
         endcase
      end
   endtask

   // Drive one cycle: model predicts, scoreboard queues, DUT is compared after the edge.
   task automatic step();
      int a;
      probe[0] = int'(alloc_dst);
      probe[1] = int'(commit_dst);
      probe[2] = 7;
      for (int i = 3; i < 6; i++) probe[i] = $urandom_range(0, 15);
      model_apply();
      push("cnt", K_CNT, 0, m_cnt);
      push("full", K_FULL, 0, (m_cnt == NC) ? 1 : 0);
      push("alloc_id", K_ID, 0, m_tail);
      for (int i = 0; i < 6; i++) begin
         a = probe[i];
         push("rd_v", K_RV, a, (a != 0 && m_v[a] != 0) ? 1 : 0);
         push("rd_t", K_RT, a, (a != 0 && m_v[a] != 0) ? m_tag[a] : 0);
      end
      @(posedge clk);
      #1;
      cyc_n++;
      idle();
      drain();
   endtask

   task automatic do_alloc(input int dst, input int tag, input bit ck);
      alloc_en = 1'b1; alloc_wen = 1'b1; alloc_dst = AW'(dst); alloc_tag = TW'(tag); alloc_ckpt = ck;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
   endtask

   task automatic t5_setup();
      do_reset();
      do_alloc(7, 4, 1'b1); step();
      do_alloc(3, 1, 1'b1); step();
      do_alloc(7, 5, 1'b0); step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc_n);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rd_addr = '0;
      idle();
      rst_n = 1'b0;
      push("rst_cnt", K_CNT, 0, 0);
      push("rst_full", K_FULL, 0, 0);
      push("rst_id", K_ID, 0, 0);
      push("rst_r5_v", K_RV, 5, 0);
      push("rst_r5_t", K_RT, 5, 0);
      step();

      // Basic rename and register 0
      do_alloc(5, 3, 1'b0);
      push("t1_r5_v", K_RV, 5, 1);
      push("t1_r5_t", K_RT, 5, 3);
      push("t1_r0_v", K_RV, 0, 0);
      push("t1_r0_t", K_RT, 0, 0);
      step();

      // Restore overwrites a younger mapping
      do_reset();
      do_alloc(5, 3, 1'b1); step();
      do_alloc(5, 7, 1'b0); push("t2_pre_r5_t", K_RT, 5, 7); step();
      recover_en = 1'b1; recover_id = 2'd0;
      push("t2_r5_t", K_RT, 5, 3);
      push("t2_cnt", K_CNT, 0, 1);
      push("t2_id", K_ID, 0, 1);
      step();

      // Commit clears the snapshot copy too
      do_reset();
      do_alloc(6, 2, 1'b1); step();
      commit_en = 1'b1; commit_dst = 5'd6; commit_tag = 4'd2; step();
      recover_en = 1'b1; recover_id = 2'd0;
      push("t3_r6_v", K_RV, 6, 0);
      step();

      // Fill, overflow attempt, free, wrap
      do_reset();
      for (int i = 0; i < NC; i++) begin
         do_alloc(i + 1, i + 1, 1'b1);
         if (i == NC - 1) begin
            push("t4_full", K_FULL, 0, 1);
            push("t4_cnt", K_CNT, 0, 4);
            push("t4_id_wrap", K_ID, 0, 0);
         end
         step();
      end
      $display("note: protocol error driven: alloc_ckpt while ckpt_full, expecting no effect");
      do_alloc(8, 5, 1'b1);
      push("t4_ovf_r8_v", K_RV, 8, 0);
      push("t4_ovf_cnt", K_CNT, 0, 4);
      step();
      commit_en = 1'b1; commit_ckpt_free = 1'b1;
      push("t4_free_cnt", K_CNT, 0, 3);
      push("t4_free_full", K_FULL, 0, 0);
      step();
      do_alloc(9, 6, 1'b1);
      push("t4_wrap_id", K_ID, 0, 1);
      push("t4_wrap_cnt", K_CNT, 0, 4);
      push("t4_r9_t", K_RT, 9, 6);
      step();
      recover_en = 1'b1; recover_id = 2'd1;
      push("t4_rec_cnt_head1", K_CNT, 0, 1);
      push("t4_rec_id", K_ID, 0, 2);
      push("t4_rec_r2_t", K_RT, 2, 2);
      push("t4_rec_r9_v", K_RV, 9, 0);
      push("t4_rec_r1_v", K_RV, 1, 1);
      step();

      // Alloc + commit + recover in one cycle, matching restored tag
      t5_setup();
      do_alloc(7, 9, 1'b0);
      commit_en = 1'b1; commit_dst = 5'd7; commit_tag = 4'd4;
      recover_en = 1'b1; recover_id = 2'd1;
      push("t5_r7_v_cleared", K_RV, 7, 0);
      push("t5_r3_t", K_RT, 3, 1);
      push("t5_cnt", K_CNT, 0, 2);
      push("t5_id", K_ID, 0, 2);
      step();

      // Same, but commit tag only matches the discarded live mapping
      t5_setup();
      do_alloc(7, 9, 1'b0);
      commit_en = 1'b1; commit_dst = 5'd7; commit_tag = 4'd5;
      recover_en = 1'b1; recover_id = 2'd1;
      push("t5b_r7_v", K_RV, 7, 1);
      push("t5b_r7_t", K_RT, 7, 4);
      step();

      // Flush with live checkpoints, then flush beating recover
      do_reset();
      for (int i = 0; i < 3; i++) begin
         do_alloc(10 + i, 1 + i, 1'b1); step();
      end
      do_alloc(13, 4, 1'b0); step();
      flush_en = 1'b1;
      push("t6_r10_v", K_RV, 10, 0);
      push("t6_r12_t", K_RT, 12, 0);
      push("t6_r13_v", K_RV, 13, 0);
      push("t6_cnt", K_CNT, 0, 0);
      push("t6_id", K_ID, 0, 0);
      step();
      do_alloc(10, 5, 1'b1); step();
      do_alloc(11, 6, 1'b1); step();
      flush_en = 1'b1; recover_en = 1'b1; recover_id = 2'd0;
      push("t6b_cnt", K_CNT, 0, 0);
      push("t6b_id", K_ID, 0, 0);
      push("t6b_r10_v", K_RV, 10, 0);
      step();

      // Reset overrides a recovery in flight
      do_alloc(14, 7, 1'b1); step();
      rst_n = 1'b0; recover_en = 1'b1; recover_id = 2'd0; do_alloc(15, 8, 1'b1);
      push("t7_cnt", K_CNT, 0, 0);
      push("t7_r14_v", K_RV, 14, 0);
      push("t7_r15_v", K_RV, 15, 0);
      step();

      // Constrained random traffic against the model
      for (int n = 0; n < 400; n++) begin
         alloc_en   = ($urandom_range(0, 3) != 0);
         alloc_dst  = AW'($urandom_range(0, 7));
         alloc_tag  = TW'($urandom_range(0, 15));
         alloc_wen  = ($urandom_range(0, 3) != 0);
         alloc_ckpt = ($urandom_range(0, 2) == 0) && (m_cnt < NC);
         commit_en  = ($urandom_range(0, 1) != 0);
         commit_dst = AW'($urandom_range(0, 7));
         commit_tag = ($urandom_range(0, 1) != 0) ? TW'(m_tag[int'(commit_dst)])
                                                  : TW'($urandom_range(0, 15));
         commit_ckpt_free = (m_cnt > 0) && ($urandom_range(0, 3) == 0);
         if (m_cnt > 0 && $urandom_range(0, 9) == 0) begin
            recover_en = 1'b1;
            recover_id = CW'((m_head + $urandom_range(0, m_cnt - 1)) % NC);
         end
         flush_en = ($urandom_range(0, 39) == 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rat_ckpt.md
# rat_ckpt

Parametrised register alias table with branch checkpoints. It maps architectural registers to ROB tags for rename, and has N combinational read ports. On a branch mispredict it restores the mapping from a snapshot instead of clearing the whole table. It sits between decode/rename and the issue queue and is updated by ROB allocate, commit, recovery and exception flush.

## Interface
- `ARCH_REGS`, 32: number of architectural registers. Register 0 is never mapped.
- `ROB_DEPTH`, 16: ROB entries. `TW = $clog2(ROB_DEPTH)`.
- `RD_PORTS`, 3: number of source read ports.
- `CKPT_NUM`, 4: number of checkpoints, power of 2. `CW = $clog2(CKPT_NUM)`.
- `AW` is `$clog2(ARCH_REGS)`.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `rd_addr` in `RD_PORTS*AW`: packed read addresses; port k is `[k*AW +: AW]`.
- `rd_valid` out `RD_PORTS`: mapping exists for port k.
- `rd_tag` out `RD_PORTS*TW`: mapped ROB tag for port k.
- `alloc_en` in 1: a rename slot is valid this cycle.
- `alloc_tag` in `TW`: ROB tag of the renamed instruction.
- `alloc_dst` in `AW`: destination architectural register.
- `alloc_wen` in 1: the instruction writes `alloc_dst`.
- `alloc_ckpt` in 1: the instruction is a branch and needs a checkpoint.
- `ckpt_alloc_id` out `CW`: id the next checkpoint will get (the tail).
- `ckpt_full` out 1: all checkpoints are in use.
- `ckpt_cnt` out `CW+1`: number of live checkpoints.
- `commit_en` in 1: a ROB entry retires.
- `commit_dst` in `AW`: destination of the retiring entry.
- `commit_tag` in `TW`: ROB tag of the retiring entry.
- `commit_ckpt_free` in 1: the retiring entry is a branch; release the oldest checkpoint.
- `recover_en` in 1: mispredict recovery.
- `recover_id` in `CW`: checkpoint to restore.
- `flush_en` in 1: exception or full flush.

## Operation
- State:
  - Live map `map_v[ARCH_REGS]` and `map_tag[ARCH_REGS]`.
  - Checkpoint arrays `ck_v[CKPT_NUM][ARCH_REGS]` and `ck_tag[...]`.
  - `ck_head`, `ck_tail` (CW bits, wrap modulo `CKPT_NUM`) and `ck_cnt`.
- Reads are combinational from the live map only. A same-cycle allocate is not bypassed. Address 0 returns valid=0, tag=0.
- Priority per cycle: `flush_en` > `recover_en` > `alloc_en`. Commit is applied in every case except flush.
- Flush:
  - Every `map_v`, every `ck_v`, head, tail and cnt go to 0.
  - Tags may keep stale values, but read outputs must show tag=0 wherever valid=0.
- Recover:
  - Live map <= checkpoint `recover_id`.
  - `ck_tail` <= `recover_id+1`. `ck_cnt` <= `((recover_id - ck_head) mod CKPT_NUM) + 1`, minus 1 if `commit_ckpt_free` is also asserted.
  - Any `alloc_en` in the same cycle is dropped.
- Allocate:
  - If `alloc_wen` and `alloc_dst != 0`: `map_v[dst]` <= 1 and `map_tag[dst]` <= `alloc_tag`.
  - If `alloc_ckpt` and not `ckpt_full`: checkpoint `ck_tail` <= live map with this allocation already applied. Then `ck_tail++` and `ck_cnt++`.
  - `alloc_ckpt` while `ckpt_full` is an upstream protocol error. The whole allocate is ignored, and the bench flags it.
- Commit:
  - If `commit_dst != 0` and `map_v[commit_dst]` and `map_tag[commit_dst] == commit_tag`: clear `map_v[commit_dst]`.
  - The same tag-match clear applies to every checkpoint entry for `commit_dst`. A restore must never reinstate a retired mapping.
  - Under recover, the clear applies to the restored value.
  - Under alloc to the same `dst`, the alloc wins because the new tag differs.
- `commit_ckpt_free`:
  - `ck_head++` and `ck_cnt--`.
  - If it coincides with a checkpoint allocate, cnt is unchanged.
  - Free with cnt=0 is an error and is ignored.
- `ckpt_full` = (`ck_cnt == CKPT_NUM`). `ckpt_alloc_id` = `ck_tail`.

## Timing
- Reset, synchronous on `rst_n`=0 at the clk edge:
  - All valids are 0, head/tail/cnt are 0.
  - `rd_valid`=0, `rd_tag`=0, `ckpt_full`=0, `ckpt_cnt`=0, `ckpt_alloc_id`=0.
  - Reset overrides all inputs, including mid-recovery.
- Updates take effect at the clk edge. They are visible on reads and status outputs in the next cycle. Read latency is 0 cycles (combinational).
- Checkpoint capture and restore each take 1 cycle. Back-to-back recover followed by alloc is legal.

## Test plan
- Reset, then alloc dst=5 tag=3. The next cycle, a read of 5 gives valid=1, tag=3. A read of 0 gives valid=0, tag=0.
- Alloc r5 tag=3 with ckpt (id0), then alloc r5 tag=7, then recover id0. A read of r5 gives tag=3, `ckpt_cnt`=1, `ckpt_alloc_id`=1.
- Alloc r6 tag=2 with ckpt, then commit r6 tag=2, then recover id0. r6 reads valid=0, because the checkpoint entry was cleared.
- Allocate `CKPT_NUM` (4) checkpoints: `ckpt_full`=1. A fifth `alloc_ckpt` changes nothing. Then a commit free gives cnt=3 and head=1. Further allocs make the tail wrap to 0.
- Same cycle: alloc r7 tag=9, commit r7 old tag=4, recover id1. Recover wins and the alloc is dropped. The commit clears r7 only if the restored tag is 4.
- Mid-stream `flush_en` with 3 live checkpoints: all reads valid=0, cnt=0, `ckpt_alloc_id`=0. `flush_en` asserted together with `recover_en`: flush takes effect.
